output_process_spi_mc: RTL and testbench

Multi-channel, parametrised output serializer for the redirection board's TX SPI path. It has N_CH independent write ports, each buffered in its own synchronous FIFO. A round-robin arbiter selects the next word, and the block serializes it as an address-plus-data frame on a single TX_DATA/TX_LOAD pair, honouring the receiver's RX_STOP back-pressure. It sits between the channel-processing logic and the board's TX connector.

---
 rtl/output_process_spi_mc_pkg.sv | 26 ++
 rtl/sync_fifo_p.sv | 58 +++++
 rtl/output_process_spi_mc.sv | 185 ++++++++++++++++++
 tb/tb_output_process_spi_mc.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_process_spi_mc_pkg.sv
// Shared definitions for the multi-channel TX SPI output serializer:
// FSM state encoding and the width helpers used by the top level and FIFOs.
package output_process_spi_mc_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StShift = 2'd2,
        StGap   = 2'd3
    } state_e;

    // Ceiling log2; callers guarantee n >= 2 where a nonzero width is needed.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/sync_fifo_p.sv
// Single-clock FIFO with registered read data; a pop while full frees the slot
// so a simultaneous push is accepted.
module sync_fifo_p
    import output_process_spi_mc_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              TX_CLK,
    input  logic              RST,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PTR_W = clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_ptr_q;
    logic [PTR_W:0]    rd_ptr_q;
    logic [DATA_W-1:0] dout_q;
    logic              do_wr;
    logic              do_rd;

    // Extra MSB on each pointer distinguishes full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);
    assign dout  = dout_q;

    always_ff @(posedge TX_CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
                dout_q   <= mem[rd_ptr_q[PTR_W-1:0]];
            end
        end
    end

    always_ff @(posedge TX_CLK) begin
        if (do_wr) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/output_process_spi_mc.sv
// Multi-channel TX SPI serializer: per-channel FIFOs, round-robin arbiter and an
// address+payload shifter with receiver back-pressure.
module output_process_spi_mc
    import output_process_spi_mc_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned N_CH      = 2,
    parameter int unsigned BASE_ADDR = 1,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                   TX_CLK,
    input  logic                   RST,
    input  logic [N_CH*DATA_W-1:0] DATA,
    input  logic [N_CH-1:0]        ENA,
    input  logic [N_CH-1:0]        OVF_CLR,
    input  logic                   RX_STOP,
    output logic                   TX_DATA,
    output logic                   TX_LOAD,
    output logic [N_CH-1:0]        FULL,
    output logic [N_CH-1:0]        OVF,
    output logic [1:0]             state_mon
);

    localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int unsigned CNT_W   = clog2(FRAME_W);
    localparam int unsigned CH_W    = (N_CH > 1) ? clog2(N_CH) : 1;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    logic [FRAME_W-1:0]  sh_q, sh_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tx_data_q, tx_data_d;
    logic                tx_load_q, tx_load_d;
    logic [N_CH-1:0]     ovf_q, ovf_d;

    logic [N_CH-1:0]     fifo_wr;
    logic [N_CH-1:0]     fifo_rd;
    logic [N_CH-1:0]     fifo_empty;
    logic [N_CH-1:0]     fifo_full;
    logic [DATA_W-1:0]   fifo_dout [N_CH];

    logic                pick_valid;
    logic [CH_W-1:0]     pick;
    logic                go;
    logic [DATA_W-1:0]   word;
    logic [ADDR_W-1:0]   addr;
    logic [FRAME_W-1:0]  frame;

    for (genvar c = 0; c < N_CH; c++) begin : g_fifo
        sync_fifo_p #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .TX_CLK (TX_CLK),
            .RST    (RST),
            .wr     (fifo_wr[c]),
            .rd     (fifo_rd[c]),
            .din    (DATA[c*DATA_W +: DATA_W]),
            .dout   (fifo_dout[c]),
            .empty  (fifo_empty[c]),
            .full   (fifo_full[c])
        );
    end

    // A full FIFO popped this cycle still accepts the write; otherwise it drops.
    assign fifo_wr = ENA & (~fifo_full | fifo_rd);
    assign ovf_d   = (ovf_q & ~OVF_CLR) | (ENA & fifo_full & ~fifo_rd);

    // Round-robin: scan starting one past the last grant.
    always_comb begin
        pick_valid = 1'b0;
        pick       = grant_q;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            int unsigned idx;
            idx = 32'(grant_q) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (!pick_valid && (c == idx) && !fifo_empty[c]) begin
                    pick_valid = 1'b1;
                    pick       = CH_W'(c);
                end
            end
        end
    end

    always_comb begin
        fifo_rd = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            fifo_rd[c] = go && (pick == CH_W'(c));
        end
    end

    // Frame assembly; LSB-first mode mirrors each field so the shifter always
    // emits from its MSB.
    always_comb begin
        word = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (grant_q == CH_W'(c)) begin
                word = fifo_dout[c];
            end
        end
        addr  = ADDR_W'(BASE_ADDR + 32'(grant_q));
        frame = {addr, word};
        if (MSB_FIRST == 0) begin
            for (int unsigned i = 0; i < ADDR_W; i++) begin
                frame[FRAME_W-1-i] = addr[i];
            end
            for (int unsigned i = 0; i < DATA_W; i++) begin
                frame[DATA_W-1-i] = word[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        tx_data_d = 1'b0;
        tx_load_d = 1'b0;
        go        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!RX_STOP && pick_valid) begin
                    go      = 1'b1;
                    grant_d = pick;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                tx_data_d = frame[FRAME_W-1];
                sh_d      = {frame[FRAME_W-2:0], 1'b0};
                cnt_d     = '0;
                state_d   = StShift;
            end
            StShift: begin
                if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                    state_d = StGap;
                end else begin
                    tx_data_d = sh_q[FRAME_W-1];
                    tx_load_d = (cnt_q == CNT_W'(FRAME_W - 2));
                    sh_d      = {sh_q[FRAME_W-2:0], 1'b0};
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge TX_CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            grant_q   <= CH_W'(N_CH - 1);
            sh_q      <= '0;
            cnt_q     <= '0;
            tx_data_q <= 1'b0;
            tx_load_q <= 1'b0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_load_q <= tx_load_d;
            ovf_q     <= ovf_d;
        end
    end

    assign TX_DATA   = tx_data_q;
    assign TX_LOAD   = tx_load_q;
    assign FULL      = fifo_full;
    assign OVF       = ovf_q;
    assign state_mon = state_q;

endmodule

// File: tb/tb_output_process_spi_mc.sv
// Directed bench: default configuration plus an LSB-first, 4-channel instance.
module tb_output_process_spi_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [1:0]  ena, ovf_clr;
    logic        rx_stop;
    logic        tx_data, tx_load;
    logic [1:0]  full, ovf, state;

    logic [31:0] data2;
    logic [3:0]  ena2, ovf_clr2;
    logic        rx_stop2;
    logic        tx_data2, tx_load2;
    logic [3:0]  full2, ovf2;
    logic [1:0]  state2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    output_process_spi_mc dut (
        .TX_CLK    (clk),
        .RST       (rst),
        .DATA      (data),
        .ENA       (ena),
        .OVF_CLR   (ovf_clr),
        .RX_STOP   (rx_stop),
        .TX_DATA   (tx_data),
        .TX_LOAD   (tx_load),
        .FULL      (full),
        .OVF       (ovf),
        .state_mon (state)
    );

    output_process_spi_mc #(
        .DATA_W    (8),
        .ADDR_W    (3),
        .DEPTH     (4),
        .N_CH      (4),
        .BASE_ADDR (1),
        .MSB_FIRST (0)
    ) dut2 (
        .TX_CLK    (clk),
        .RST       (rst),
        .DATA      (data2),
        .ENA       (ena2),
        .OVF_CLR   (ovf_clr2),
        .RX_STOP   (rx_stop2),
        .TX_DATA   (tx_data2),
        .TX_LOAD   (tx_load2),
        .FULL      (full2),
        .OVF       (ovf2),
        .state_mon (state2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples n consecutive bits, first bit ends up most significant.
    task automatic grab(input bit sel, input int n, input int raise_at,
                        output logic [31:0] bits, output logic [31:0] loads);
        bits  = '0;
        loads = '0;
        for (int i = 0; i < n; i++) begin
            bits  = {bits[30:0], (sel ? tx_data2 : tx_data)};
            loads = {loads[30:0], (sel ? tx_load2 : tx_load)};
            if (i == raise_at) rx_stop = 1'b1;
            tick();
        end
    endtask

    task automatic wait_shift(input bit sel, input string tag, output int waited);
        waited = 0;
        while (((sel ? state2 : state) != 2'd2) && (waited < 50)) begin
            tick();
            waited++;
        end
        check(tag, 32'(sel ? state2 : state), 32'd2);
    endtask

    task automatic do_reset();
        ena = '0; ena2 = '0; ovf_clr = '0; rx_stop = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] bits, loads;
        logic [15:0] rr_w [6];
        logic [10:0] exp2 [4];
        int          waited, bad;

        rst = 1'b0; data = '0; ena = '0; ovf_clr = '0; rx_stop = 1'b0;
        data2 = '0; ena2 = '0; ovf_clr2 = '0; rx_stop2 = 1'b0;
        ticks(2);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_load", 32'(tx_load), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        rst = 1'b1;
        tick();

        // Single word on channel 0, default parameters.
        data = {16'h0000, 16'hA5C3}; ena = 2'b01;
        tick();
        ena = 2'b00;
        check("single_idle", 32'(state), 32'd0);
        tick();
        check("single_fetch", 32'(state), 32'd1);
        tick();
        check("single_shift", 32'(state), 32'd2);
        grab(1'b0, 19, -1, bits, loads);
        check("single_bits", bits, 32'b0011010010111000011);
        check("single_load", loads, 32'd1);
        check("single_gap_state", 32'(state), 32'd3);
        check("single_gap_data", 32'({tx_data, tx_load}), 32'd0);
        tick();
        check("single_back_idle", 32'(state), 32'd0);

        // Round-robin between two preloaded channels.
        do_reset();
        rr_w = '{16'h1111, 16'hAAAA, 16'h2222, 16'hBBBB, 16'h3333, 16'hCCCC};
        rx_stop = 1'b1;
        data = {16'hAAAA, 16'h1111}; ena = 2'b11; tick();
        data = {16'hBBBB, 16'h2222}; tick();
        data = {16'hCCCC, 16'h3333}; tick();
        ena = 2'b00;
        rx_stop = 1'b0;
        wait_shift(1'b0, "rr_start", waited);
        check("rr_latency", 32'(waited), 32'd2);
        for (int f = 0; f < 6; f++) begin
            grab(1'b0, 19, -1, bits, loads);
            check($sformatf("rr_frame%0d", f), bits,
                  32'({((f % 2 == 0) ? 3'd1 : 3'd2), rr_w[f]}));
            check($sformatf("rr_load%0d", f), loads, 32'd1);
            if (f < 5) begin
                ticks(3);
                check($sformatf("rr_period%0d", f), 32'(state), 32'd2);
            end
        end

        // Overflow on channel 1 with the receiver stalled.
        do_reset();
        rx_stop = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            data = {16'h0100 + 16'(i), 16'h0000}; ena = 2'b10;
            tick();
            if (i == 15) check("ovf_full_w15", 32'(full), 32'd0);
            if (i == 16) begin
                check("ovf_full_w16", 32'(full), 32'd2);
                check("ovf_clear_w16", 32'(ovf), 32'd0);
            end
            if (i == 17) begin
                check("ovf_set_w17", 32'(ovf), 32'd2);
                check("ovf_full_w17", 32'(full), 32'd2);
            end
        end
        ena = 2'b00;
        rx_stop = 1'b0;
        wait_shift(1'b0, "ovf_start", waited);
        for (int i = 1; i <= 16; i++) begin
            grab(1'b0, 19, -1, bits, loads);
            check($sformatf("ovf_word%0d", i), bits, 32'({3'd2, 16'h0100 + 16'(i)}));
            if (i < 16) ticks(3);
        end
        ticks(3);
        check("ovf_drained_state", 32'(state), 32'd0);
        check("ovf_drained_full", 32'(full), 32'd0);
        check("ovf_sticky", 32'(ovf), 32'd2);
        ovf_clr = 2'b10;
        tick();
        ovf_clr = 2'b00;
        check("ovf_cleared", 32'(ovf), 32'd0);

        // RX_STOP raised mid-frame.
        do_reset();
        data = {16'h0000, 16'h1234}; ena = 2'b01; tick();
        data = {16'h0000, 16'h5678}; tick();
        ena = 2'b00;
        wait_shift(1'b0, "stop_start", waited);
        grab(1'b0, 19, 5, bits, loads);
        check("stop_frame_done", bits, 32'({3'd1, 16'h1234}));
        check("stop_gap", 32'(state), 32'd3);
        tick();
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (state != 2'd0) bad++;
            tick();
        end
        check("stop_hold_idle", 32'(bad), 32'd0);
        rx_stop = 1'b0;
        tick();
        check("stop_resume_fetch", 32'(state), 32'd1);
        tick();
        check("stop_resume_shift", 32'(state), 32'd2);
        grab(1'b0, 19, -1, bits, loads);
        check("stop_second_frame", bits, 32'({3'd1, 16'h5678}));

        // Asynchronous reset at bit 10 with channel 1 full.
        do_reset();
        rx_stop = 1'b1;
        data = {16'h0200, 16'hFFFF}; ena = 2'b11; tick();
        ena = 2'b10;
        for (int i = 1; i < 16; i++) begin
            data = {16'h0200 + 16'(i), 16'h0000};
            tick();
        end
        ena = 2'b00;
        check("arst_pre_full", 32'(full), 32'd2);
        rx_stop = 1'b0;
        wait_shift(1'b0, "arst_start", waited);
        ticks(10);
        check("arst_pre_bit10", 32'(tx_data), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_tx_data", 32'(tx_data), 32'd0);
        check("arst_tx_load", 32'(tx_load), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        check("arst_state", 32'(state), 32'd0);
        tick();
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (state != 2'd0 || tx_data != 1'b0) bad++;
        end
        check("arst_no_stale", 32'(bad), 32'd0);

        // LSB-first, 8-bit, 4-channel instance.
        exp2 = '{11'b100_10000000, 11'b010_01000001, 11'b110_11000010, 11'b001_00100011};
        data2 = {8'hC4, 8'h43, 8'h82, 8'h01}; ena2 = 4'hF;
        tick();
        ena2 = 4'h0;
        tick();
        check("sweep_fetch", 32'(state2), 32'd1);
        tick();
        check("sweep_shift", 32'(state2), 32'd2);
        for (int c = 0; c < 4; c++) begin
            grab(1'b1, 11, -1, bits, loads);
            check($sformatf("sweep_frame%0d", c), bits, 32'(exp2[c]));
            check($sformatf("sweep_load%0d", c), loads, 32'd1);
            if (c < 3) begin
                ticks(3);
                check($sformatf("sweep_period%0d", c), 32'(state2), 32'd2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
